// File: rtl/pio_bus_arbiter.sv
// pio_bus_arbiter: shares one Avalon-style PIO register slave between two
// requesters. Each accepted request occupies the bus for one ACCESS cycle,
// followed by a one-cycle RESP where the granted requester gets its done
// pulse (plus read data for reads).
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   reqN_valid/write/address/writedata   request inputs, N = 0, 1
//   reqN_ready                      combinational accept strobe (IDLE only)
//   reqN_done, reqN_readdata        registered completion pulse / read result
//   av_address/chipselect/write_n/writedata   registered slave bus
//   av_readdata                     slave read data (combinational from address)
//   busy                            high whenever the FSM is not in IDLE
//
// Configuration:
//   PIO_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins contention;
//                          otherwise contention is resolved round-robin.
module pio_bus_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_writedata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_readdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_writedata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_readdata,

    output logic [ADDR_W-1:0] av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept_c;
    logic              grant_sel_c;   // 0 = requester 0, 1 = requester 1
    logic              sel_write_c;
    logic [ADDR_W-1:0] sel_address_c;
    logic [DATA_W-1:0] sel_writedata_c;

    logic              last_grant;
    logic              cur_grant;
    logic              cur_write;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, arbitration and handshake decode
    always_comb begin
        state_next  = state;
        accept_c    = 1'b0;
        grant_sel_c = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

`ifdef PIO_ARB_FIXED_PRIO_EN
        grant_sel_c = !req0_valid;
`else
        // Under contention the requester not granted last time wins.
        if (req0_valid && req1_valid) begin
            grant_sel_c = !last_grant;
        end else begin
            grant_sel_c = req1_valid;
        end
`endif

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_c   = 1'b1;
                    state_next = ACCESS;
                    req0_ready = !grant_sel_c;
                    req1_ready = grant_sel_c;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request field mux for the winning requester
    always_comb begin
        sel_write_c     = grant_sel_c ? req1_write     : req0_write;
        sel_address_c   = grant_sel_c ? req1_address   : req0_address;
        sel_writedata_c = grant_sel_c ? req1_writedata : req0_writedata;
    end

    // Bus drive, grant bookkeeping and completion signalling.
    // The av_* registers load on the accept edge so they are live exactly
    // during ACCESS and return to idle values on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= 1'b1;
            cur_grant     <= 1'b0;
            cur_write     <= 1'b0;
            busy          <= 1'b0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_address    <= '0;
            av_writedata  <= '0;
            req0_done     <= 1'b0;
            req1_done     <= 1'b0;
            req0_readdata <= '0;
            req1_readdata <= '0;
        end else begin
            busy          <= (state_next != IDLE);
            av_chipselect <= accept_c;
            av_write_n    <= !(accept_c && sel_write_c);
            av_address    <= accept_c ? sel_address_c   : ADDR_W'(0);
            av_writedata  <= accept_c ? sel_writedata_c : DATA_W'(0);

            if (accept_c) begin
                last_grant <= grant_sel_c;
                cur_grant  <= grant_sel_c;
                cur_write  <= sel_write_c;
            end

            req0_done <= (state == ACCESS) && !cur_grant;
            req1_done <= (state == ACCESS) &&  cur_grant;

            // Read data is sampled at the end of ACCESS while the address is still driven.
            if ((state == ACCESS) && !cur_write) begin
                if (cur_grant) begin
                    req1_readdata <= av_readdata;
                end else begin
                    req0_readdata <= av_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_bus_arbiter.sv
// Directed bench for pio_bus_arbiter: reset state, single write/read,
// contention ordering, reset mid-transaction and back-to-back accepts.
module tb_pio_bus_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              req0_valid, req0_write, req0_ready, req0_done;
    logic [ADDR_W-1:0] req0_address;
    logic [DATA_W-1:0] req0_writedata, req0_readdata;
    logic              req1_valid, req1_write, req1_ready, req1_done;
    logic [ADDR_W-1:0] req1_address;
    logic [DATA_W-1:0] req1_writedata, req1_readdata;
    logic [ADDR_W-1:0] av_address;
    logic              av_chipselect, av_write_n;
    logic [DATA_W-1:0] av_writedata, av_readdata;
    logic              busy;

    logic [DATA_W-1:0] rd_table [4];

    int n_pass;
    int n_total;

    assign av_readdata = rd_table[av_address];

    pio_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_write     (req0_write),
        .req0_address   (req0_address),
        .req0_writedata (req0_writedata),
        .req0_ready     (req0_ready),
        .req0_done      (req0_done),
        .req0_readdata  (req0_readdata),
        .req1_valid     (req1_valid),
        .req1_write     (req1_write),
        .req1_address   (req1_address),
        .req1_writedata (req1_writedata),
        .req1_ready     (req1_ready),
        .req1_done      (req1_done),
        .req1_readdata  (req1_readdata),
        .av_address     (av_address),
        .av_chipselect  (av_chipselect),
        .av_write_n     (av_write_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic exp_grant [4];
        logic [DATA_W-1:0] exp_rd;

        n_pass  = 0;
        n_total = 0;
        rd_table[0] = 32'h1234_5678;
        rd_table[1] = 32'hA1A1_0001;
        rd_table[2] = 32'hB2B2_0002;
        rd_table[3] = 32'hC3C3_0003;

`ifdef PIO_ARB_FIXED_PRIO_EN
        exp_grant[0] = 1'b0; exp_grant[1] = 1'b0; exp_grant[2] = 1'b0; exp_grant[3] = 1'b0;
`else
        exp_grant[0] = 1'b0; exp_grant[1] = 1'b1; exp_grant[2] = 1'b0; exp_grant[3] = 1'b1;
`endif

        reset = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_address = '0; req0_writedata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_address = '0; req1_writedata = '0;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_busy",    64'(busy),          64'd0);
        check("rst_ready0",  64'(req0_ready),    64'd0);
        check("rst_ready1",  64'(req1_ready),    64'd0);
        check("rst_done0",   64'(req0_done),     64'd0);
        check("rst_done1",   64'(req1_done),     64'd0);
        check("rst_rd0",     64'(req0_readdata), 64'd0);
        check("rst_rd1",     64'(req1_readdata), 64'd0);
        check("rst_cs",      64'(av_chipselect), 64'd0);
        check("rst_wn",      64'(av_write_n),    64'd1);
        check("rst_addr",    64'(av_address),    64'd0);
        check("rst_wdata",   64'(av_writedata),  64'd0);
        reset = 1'b0;

        // req0 write addr 0 data 0xA5
        tick();
        req0_valid = 1'b1; req0_write = 1'b1; req0_address = 2'd0; req0_writedata = 32'h0000_00A5;
        #1;
        check("w_ready0_T",  64'(req0_ready),    64'd1);
        check("w_ready1_T",  64'(req1_ready),    64'd0);
        check("w_busy_T",    64'(busy),          64'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("w_cs_T1",     64'(av_chipselect), 64'd1);
        check("w_wn_T1",     64'(av_write_n),    64'd0);
        check("w_addr_T1",   64'(av_address),    64'd0);
        check("w_wdata_T1",  64'(av_writedata),  64'h0000_00A5);
        check("w_busy_T1",   64'(busy),          64'd1);
        check("w_ready0_T1", 64'(req0_ready),    64'd0);
        tick();
        check("w_done0_T2",  64'(req0_done),     64'd1);
        check("w_done1_T2",  64'(req1_done),     64'd0);
        check("w_cs_T2",     64'(av_chipselect), 64'd0);
        check("w_wn_T2",     64'(av_write_n),    64'd1);
        check("w_wdata_T2",  64'(av_writedata),  64'd0);
        tick();
        check("w_done0_T3",  64'(req0_done),     64'd0);
        check("w_busy_T3",   64'(busy),          64'd0);

        // req1 read addr 0
        req1_valid = 1'b1; req1_write = 1'b0; req1_address = 2'd0;
        #1;
        check("r_ready1_T",  64'(req1_ready),    64'd1);
        check("r_ready0_T",  64'(req0_ready),    64'd0);
        tick();
        req1_valid = 1'b0;
        #1;
        check("r_cs_T1",     64'(av_chipselect), 64'd1);
        check("r_wn_T1",     64'(av_write_n),    64'd1);
        check("r_addr_T1",   64'(av_address),    64'd0);
        tick();
        check("r_done1_T2",  64'(req1_done),     64'd1);
        check("r_done0_T2",  64'(req0_done),     64'd0);
        check("r_rd1_T2",    64'(req1_readdata), 64'h1234_5678);
        check("r_rd0_T2",    64'(req0_readdata), 64'd0);
        tick();
        check("r_done1_T3",  64'(req1_done),     64'd0);
        check("r_rd1_hold",  64'(req1_readdata), 64'h1234_5678);

        // Contention: both valid every IDLE cycle, four transactions
        req0_valid = 1'b1; req0_write = 1'b0; req0_address = 2'd1;
        req1_valid = 1'b1; req1_write = 1'b0; req1_address = 2'd2;
        for (int k = 0; k < 4; k++) begin
            exp_rd = exp_grant[k] ? rd_table[2] : rd_table[1];
            #1;
            check($sformatf("arb%0d_ready0", k), 64'(req0_ready), 64'(!exp_grant[k]));
            check($sformatf("arb%0d_ready1", k), 64'(req1_ready), 64'(exp_grant[k]));
            tick();
            check($sformatf("arb%0d_addr", k), 64'(av_address), exp_grant[k] ? 64'd2 : 64'd1);
            tick();
            check($sformatf("arb%0d_done0", k), 64'(req0_done), 64'(!exp_grant[k]));
            check($sformatf("arb%0d_done1", k), 64'(req1_done), 64'(exp_grant[k]));
            check($sformatf("arb%0d_rd", k),
                  64'(exp_grant[k] ? req1_readdata : req0_readdata), 64'(exp_rd));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during ACCESS of a read
        tick();
        req0_valid = 1'b1; req0_write = 1'b0; req0_address = 2'd3;
        #1;
        check("ra_ready0_T", 64'(req0_ready),    64'd1);
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("ra_cs_T1",    64'(av_chipselect), 64'd1);
        tick();
        reset = 1'b0;
        #1;
        check("ra_busy",     64'(busy),          64'd0);
        check("ra_cs",       64'(av_chipselect), 64'd0);
        check("ra_done0",    64'(req0_done),     64'd0);
        check("ra_done1",    64'(req1_done),     64'd0);
        check("ra_rd0",      64'(req0_readdata), 64'd0);
        tick();
        check("ra_done0_n",  64'(req0_done),     64'd0);
        check("ra_busy_n",   64'(busy),          64'd0);

        // Back-to-back writes from req0 with valid held high
        req0_valid = 1'b1; req0_write = 1'b1; req0_address = 2'd2; req0_writedata = 32'h5A5A_0F0F;
        #1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("b2b%0d_ready0", i), 64'(req0_ready), 64'((i % 3) == 0));
            check($sformatf("b2b%0d_ready1", i), 64'(req1_ready), 64'd0);
            if ((i % 3) == 1) begin
                check($sformatf("b2b%0d_wn", i), 64'(av_write_n), 64'd0);
            end
            tick();
        end
        req0_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
